// File: rtl/health_alarm_manager.sv
// health_alarm_manager: debounces the first-phase detector flags, latches
// confirmed conditions as sticky pending events, serves one prioritised alarm
// at a time with timeout escalation, and keeps a saturating event count.
//
// state     | meaning
// IDLE      | no alarm active; waits for any pending event
// ALARM     | alarm_code active, timeout timer running
// ESCALATED | alarm_code active past timeout, waiting for ack
module health_alarm_manager #(
  parameter int DEBOUNCE = 4,
  parameter int TIMEOUT  = 16,
  parameter int GI_HIGH  = 12,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic             presureAbnormality,
  input  logic             bloodAbnormality,
  input  logic             fallDetected,
  input  logic             temperatureAbnormality,
  input  logic [3:0]       glycemicIndex,
  input  logic             ack,
  output logic             alarm,
  output logic [2:0]       alarm_code,
  output logic             escalate,
  output logic [4:0]       pending,
  output logic [CNT_W-1:0] event_count
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ALARM     = 2'd1,
    ESCALATED = 2'd2
  } stateT;

  localparam logic [3:0]       DEB_MAX    = 4'(DEBOUNCE);
  localparam logic [3:0]       DEB_PRE    = 4'(DEBOUNCE - 1);
  localparam logic [7:0]       TIMER_LOAD = 8'(TIMEOUT - 1);
  localparam logic [4:0]       GI_TH      = 5'(GI_HIGH);
  localparam logic [CNT_W+2:0] CNT_MAX    = {3'b000, {CNT_W{1'b1}}};

  stateT            state, stateNext;
  logic [7:0]       timer, timerNext;
  logic [2:0]       codeNext;
  logic             escNext;
  logic [3:0]       debCnt [4];
  logic             fallHist;
  logic [3:0]       abnormal;
  logic [4:0]       confirm, ackClear, pendingNext;
  logic [2:0]       nConfirm, lowestCode;
  logic [CNT_W+2:0] countSum;

  // debounced conditions in pending-bit order: pressure, blood, temperature, glycemic
  assign abnormal = {({1'b0, glycemicIndex} >= GI_TH), temperatureAbnormality,
                     bloodAbnormality, presureAbnormality};

  assign alarm = (state != IDLE);

  // Confirmation pulses: counter crossing DEBOUNCE-1 -> DEBOUNCE, or a rising fall flag.
  always_comb begin
    confirm  = '0;
    nConfirm = '0;
    if (sample_valid) begin
      confirm[0] = fallDetected & ~fallHist;
      for (int i = 0; i < 4; i++) begin
        confirm[i+1] = abnormal[i] && (debCnt[i] == DEB_PRE);
      end
    end
    for (int i = 0; i < 5; i++) begin
      nConfirm = nConfirm + {2'b00, confirm[i]};
    end
    countSum = {3'b000, event_count} + {{CNT_W{1'b0}}, nConfirm};
  end

  // Debounce counters and fall history advance only on valid samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) debCnt[i] <= '0;
      fallHist <= 1'b0;
    end else if (sample_valid) begin
      for (int i = 0; i < 4; i++) begin
        if (!abnormal[i])             debCnt[i] <= '0;
        else if (debCnt[i] != DEB_MAX) debCnt[i] <= debCnt[i] + 4'd1;
      end
      fallHist <= fallDetected;
    end
  end

  // Saturating count of confirmed events.
  always_ff @(posedge clk) begin
    if (rst)                      event_count <= '0;
    else if (countSum > CNT_MAX)  event_count <= '1;
    else                          event_count <= countSum[CNT_W-1:0];
  end

  // Next-state logic; fall (bit 0) has the highest priority.
  always_comb begin
    stateNext  = state;
    timerNext  = timer;
    codeNext   = alarm_code;
    escNext    = escalate;
    ackClear   = '0;
    lowestCode = '0;
    for (int i = 4; i >= 0; i--) begin
      if (pending[i]) lowestCode = 3'(i + 1);
    end
    case (state)
      IDLE: begin
        if (pending != '0) begin
          stateNext = ALARM;
          codeNext  = lowestCode;
          timerNext = TIMER_LOAD;
          escNext   = 1'b0;
        end
      end
      ALARM: begin
        if (ack) begin
          ackClear  = 5'd1 << (alarm_code - 3'd1);
          stateNext = IDLE;
          codeNext  = '0;
        end else if (timer == '0) begin
          stateNext = ESCALATED;
          escNext   = 1'b1;
        end else begin
          timerNext = timer - 8'd1;
        end
      end
      ESCALATED: begin
        if (ack) begin
          ackClear  = 5'd1 << (alarm_code - 3'd1);
          stateNext = IDLE;
          codeNext  = '0;
          escNext   = 1'b0;
        end
      end
      default: begin
        stateNext = IDLE;
        codeNext  = '0;
        escNext   = 1'b0;
      end
    endcase
    // a confirmation landing on the bit being acknowledged keeps it pending
    pendingNext = (pending & ~ackClear) | confirm;
  end

  // FSM state, timer, registered alarm outputs and pending events.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      alarm_code <= '0;
      escalate   <= 1'b0;
      pending    <= '0;
    end else begin
      state      <= stateNext;
      timer      <= timerNext;
      alarm_code <= codeNext;
      escalate   <= escNext;
      pending    <= pendingNext;
    end
  end

endmodule
